// File: rtl/rd_sipo_frame.sv
// rd_sipo_frame: framed serial-to-parallel deserializer with Valid/Ready hold register.
// Optional even-parity bit per frame when RD_SIPO_PARITY_EN is defined.
module rd_sipo_frame #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLRbar,
  input  logic             SerIn,
  input  logic             SerEn,
  input  logic             Start,
  input  logic             Ready,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Busy,
`ifdef RD_SIPO_PARITY_EN
  output logic             ParErr,
`endif
  output logic             Overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef RD_SIPO_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, word;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             done;
`ifdef RD_SIPO_PARITY_EN
  logic             par_q, par_d, perr;
`endif

  assign sr_sh = MSB_FIRST ? {sr_q[WIDTH-2:0], SerIn}
                           : {SerIn, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = valid_q & ~Ready;
    ovr_d   = ovr_q;
    done    = 1'b0;
    word    = sr_sh;
`ifdef RD_SIPO_PARITY_EN
    par_d   = par_q;
    perr    = 1'b0;
`endif
    // Start beats completion: a restart never delivers the old frame
    if (Start) begin
      state_d = SHIFT;
      cnt_d   = SerEn ? CW'(1) : '0;
      if (SerEn) sr_d = sr_sh;
    end else begin
      case (state_q)
        SHIFT: begin
          if (SerEn) begin
            sr_d  = sr_sh;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
`ifdef RD_SIPO_PARITY_EN
              state_d = PAR;
`else
              done    = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
`endif
            end
          end
        end
`ifdef RD_SIPO_PARITY_EN
        PAR: begin
          if (SerEn) begin
            done    = 1'b1;
            word    = sr_q;
            perr    = ^{sr_q, SerIn};
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`endif
        default: ;
      endcase
    end
    if (done) begin
      if (!valid_q || Ready) begin
        q_d     = word;
        valid_d = 1'b1;
`ifdef RD_SIPO_PARITY_EN
        par_d   = perr;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLRbar) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RD_SIPO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef RD_SIPO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Q       = q_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;
  assign Busy    = (state_q != IDLE);
`ifdef RD_SIPO_PARITY_EN
  assign ParErr  = par_q;
`endif

endmodule

// File: tb/tb_rd_sipo_frame.sv
// tb_rd_sipo_frame: directed checks of rd_sipo_frame, both bit orders.
// Parity cases are built only when RD_SIPO_PARITY_EN is defined.
module tb_rd_sipo_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ser_in, ser_en, start, ready;
  logic [9:0] q_m, q_l;
  logic       v_m, b_m, o_m, v_l, b_l, o_l;
`ifdef RD_SIPO_PARITY_EN
  logic       pe_m, pe_l;
`endif

  int n_run  = 0;
  int n_fail = 0;

  rd_sipo_frame #(.WIDTH(10), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .CLRbar(rst_n), .SerIn(ser_in), .SerEn(ser_en),
    .Start(start), .Ready(ready), .Q(q_m), .Valid(v_m), .Busy(b_m),
`ifdef RD_SIPO_PARITY_EN
    .ParErr(pe_m),
`endif
    .Overrun(o_m)
  );

  rd_sipo_frame #(.WIDTH(10), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .CLRbar(rst_n), .SerIn(ser_in), .SerEn(ser_en),
    .Start(start), .Ready(ready), .Q(q_l), .Valid(v_l), .Busy(b_l),
`ifdef RD_SIPO_PARITY_EN
    .ParErr(pe_l),
`endif
    .Overrun(o_l)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_(input logic s, input logic d);
    start  = s;
    ser_en = 1'b1;
    ser_in = d;
    tick();
    start  = 1'b0;
    ser_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // b[9] is the first bit on the wire
  task automatic send(input logic [9:0] b, input int gap, input logic flip);
    for (int i = 0; i < 10; i++) begin
      bit_(i == 0, b[9-i]);
      if (i == 0) chk("busy_first", b_m, 1);
      if (i < 9) repeat (gap) tick();
      if (gap > 0 && i == 4) chk("busy_gap", b_m, 1);
    end
`ifdef RD_SIPO_PARITY_EN
    bit_(1'b0, (^b) ^ flip);
`else
    if (flip) $display("note: parity flip ignored");
`endif
  endtask

  initial begin
    rst_n = 1'b1; ser_in = 1'b0; ser_en = 1'b0;
    start = 1'b0; ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ser_in = 1'($urandom);
      ser_en = 1'($urandom);
      start  = 1'($urandom);
      ready  = 1'($urandom);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("rst_q", q_m, 0);
    chk("rst_valid", v_m, 0);
    chk("rst_busy", b_m, 0);
    chk("rst_ovr", o_m, 0);
    rst_n = 1'b1; start = 1'b0; ser_en = 1'b0; ready = 1'b1;

    bit_(1'b1, 1'b1); bit_(1'b0, 1'b0);
    bit_(1'b0, 1'b1); bit_(1'b0, 1'b1);
    chk("mid_busy", b_m, 1);
    do_reset();
    chk("midrst_q", q_m, 0);
    chk("midrst_valid", v_m, 0);
    chk("midrst_busy", b_m, 0);

    send(10'h2CB, 0, 1'b0);
    chk("basic_q_msb", q_m, 32'h2CB);
    chk("basic_q_lsb", q_l, 32'h34D);
    chk("basic_valid", v_m, 1);
    chk("basic_busy", b_m, 0);
    tick();
    chk("basic_valid_drop", v_m, 0);
    chk("basic_q_hold", q_m, 32'h2CB);

    do_reset();
    send(10'h2CB, 3, 1'b0);
    chk("gap_q_msb", q_m, 32'h2CB);
    chk("gap_q_lsb", q_l, 32'h34D);
    chk("gap_valid", v_m, 1);
    chk("gap_busy_end", b_m, 0);
    tick();

    ready = 1'b0;
    send(10'h155, 0, 1'b0);
    chk("bp_a_q", q_m, 32'h155);
    chk("bp_a_ovr", o_m, 0);
    send(10'h0AA, 0, 1'b0);
    chk("bp_b_q", q_m, 32'h155);
    chk("bp_b_q_lsb", q_l, 32'h2AA);
    chk("bp_b_valid", v_m, 1);
    chk("bp_b_ovr", o_m, 1);
    ready = 1'b1;
    tick();
    chk("bp_acc_valid", v_m, 0);
    chk("bp_acc_ovr", o_m, 1);

    do_reset();
    bit_(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) bit_(1'b0, 1'b1);
    chk("abort_part_valid", v_m, 0);
    send(10'h3FF, 0, 1'b0);
    chk("abort_q", q_m, 32'h3FF);
    chk("abort_valid", v_m, 1);
    chk("abort_ovr", o_m, 0);
    tick();
    chk("abort_single", v_m, 0);

    // Start lands on the edge that would otherwise complete a frame
    bit_(1'b1, 1'b0);
`ifdef RD_SIPO_PARITY_EN
    for (int i = 0; i < 9; i++) bit_(1'b0, 1'b0);
`else
    for (int i = 0; i < 8; i++) bit_(1'b0, 1'b0);
`endif
    bit_(1'b1, 1'b1);
    chk("coll_valid", v_m, 0);
    chk("coll_q", q_m, 32'h3FF);
    chk("coll_busy", b_m, 1);
    for (int i = 1; i < 10; i++) bit_(1'b0, (i == 9));
`ifdef RD_SIPO_PARITY_EN
    bit_(1'b0, 1'b0);
`endif
    chk("coll_new_q", q_m, 32'h201);
    chk("coll_new_valid", v_m, 1);
    chk("coll_ovr", o_m, 0);
    tick();

`ifdef RD_SIPO_PARITY_EN
    send(10'h2CB, 0, 1'b0);
    chk("par_ok_q", q_m, 32'h2CB);
    chk("par_ok_err", pe_m, 0);
    tick();
    send(10'h2CB, 0, 1'b1);
    chk("par_bad_err", pe_m, 1);
    chk("par_bad_valid", v_m, 1);
    chk("par_bad_err_lsb", pe_l, 1);
    do_reset();
    chk("par_rst_err", pe_m, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
